// File: rtl/arb_pkg.sv
// Shared definitions for the two-channel round-robin arbiter.
package arb_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/mux2x1.sv
// One-bit two-input multiplexer used as the arbiter's data path slice.
module mux2x1 (
    input  logic i0,
    input  logic i1,
    input  logic S,
    output logic Y
);

    assign Y = S ? i1 : i0;

endmodule

// File: rtl/arb_rr2x1.sv
// Two-channel round-robin arbiter with valid/ready handshakes feeding a
// one-entry output register through a bank of 1-bit muxes.
module arb_rr2x1
    import arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             S
);

    estado_t          state;
    estado_t          state_nx;
    logic             free;
    logic             grant_en;
    logic             grant;
    logic             s_reg;
    logic [WIDTH-1:0] mux_y;

    assign y_valid = (state == LLENO);
    assign S       = s_reg;

    // A tie goes to the channel not granted last; readies stay low during reset.
    always_comb begin
        free     = !y_valid || y_ready;
        grant_en = free && (i0_valid || i1_valid) && !rst;
        grant    = CH0;
        if (i0_valid && i1_valid) begin
            grant = ~s_reg;
        end else if (i1_valid) begin
            grant = CH1;
        end
        state_nx = state;
        if (grant_en) begin
            state_nx = LLENO;
        end else if ((state == LLENO) && y_ready) begin
            state_nx = VACIO;
        end
    end

    assign i0_ready = grant_en && (grant == CH0);
    assign i1_ready = grant_en && (grant == CH1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        mux2x1 u_mux (
            .i0 (i0_data[b]),
            .i1 (i1_data[b]),
            .S  (grant),
            .Y  (mux_y[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= VACIO;
        end else begin
            state <= state_nx;
        end
    end

    // Reset value of S=1 makes the first tie after reset go to channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_data <= '0;
            s_reg  <= CH1;
        end else if (grant_en) begin
            y_data <= mux_y;
            s_reg  <= grant;
        end
    end

endmodule
